// File: rtl/ship_placer.sv
// ============================================================================
// Module      : ship_placer
// Description : Battleship board writer. Places single-cell ships into an
//               occupancy map, serves combinational queries and sinks hits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ship_placer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NSHIPS = 4,
    parameter int RW     = 2,
    parameter int CW     = 2,
    parameter int NW     = 3
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [RW-1:0] rowsel,
    input  logic [CW-1:0] colsel,
    input  logic          btnplace,
    input  logic          btnclr,
    input  logic [RW-1:0] qrow,
    input  logic [CW-1:0] qcol,
    input  logic          hit,
    output logic          qship,
    output logic          ready,
    output logic          gameover,
    output logic [NW-1:0] shipcnt,
    output logic [NW-1:0] alive,
    output logic          errled
);

    localparam int            c_cells  = ROWS * COLS;
    localparam logic [NW-1:0] c_nships = NW'(NSHIPS);
    localparam logic [NW-1:0] c_one    = NW'(1);

    localparam logic [1:0] S_PLACE = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    logic [1:0]         r_state;
    logic [c_cells-1:0] r_map;
    logic [NW-1:0]      r_shipcnt;
    logic [NW-1:0]      r_alive;
    logic               r_ready;
    logic               r_gameover;
    logic               r_errled;

    logic r_place_s1, r_place_s2, r_place_prev;
    logic r_clr_s1, r_clr_s2, r_clr_prev;

    logic [c_cells-1:0] w_psel;
    logic [c_cells-1:0] w_qsel;
    logic               w_place_ev;
    logic               w_clr_ev;
    logic               w_pinrange;
    logic               w_pocc;
    logic               w_qhit;

    // One-hot cell decoders; an out-of-range address selects no cell at all.
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                assign w_psel[r*COLS+c] = (rowsel == RW'(r)) && (colsel == CW'(c));
                assign w_qsel[r*COLS+c] = (qrow == RW'(r)) && (qcol == CW'(c));
            end
        end
    endgenerate

    assign w_pinrange = |w_psel;
    assign w_pocc     = |(r_map & w_psel);
    assign w_qhit     = |(r_map & w_qsel);
    assign w_place_ev = r_place_s2 & ~r_place_prev;
    assign w_clr_ev   = r_clr_s2 & ~r_clr_prev;

    assign qship    = w_qhit;
    assign ready    = r_ready;
    assign gameover = r_gameover;
    assign shipcnt  = r_shipcnt;
    assign alive    = r_alive;
    assign errled   = r_errled;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_place_s1   <= 1'b0;
            r_place_s2   <= 1'b0;
            r_place_prev <= 1'b0;
            r_clr_s1     <= 1'b0;
            r_clr_s2     <= 1'b0;
            r_clr_prev   <= 1'b0;
        end else begin
            r_place_s1   <= btnplace;
            r_place_s2   <= r_place_s1;
            r_place_prev <= r_place_s2;
            r_clr_s1     <= btnclr;
            r_clr_s2     <= r_clr_s1;
            r_clr_prev   <= r_clr_s2;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_PLACE;
            r_map      <= '0;
            r_shipcnt  <= '0;
            r_alive    <= '0;
            r_ready    <= 1'b0;
            r_gameover <= 1'b0;
            r_errled   <= 1'b0;
        end else if (w_clr_ev) begin
            r_state    <= S_PLACE;
            r_map      <= '0;
            r_shipcnt  <= '0;
            r_alive    <= '0;
            r_ready    <= 1'b0;
            r_gameover <= 1'b0;
            r_errled   <= 1'b0;
        end else begin
            case (r_state)
                S_PLACE: begin
                    if (w_place_ev) begin
                        if (w_pinrange && !w_pocc) begin
                            r_map     <= r_map | w_psel;
                            r_shipcnt <= r_shipcnt + c_one;
                            r_errled  <= 1'b0;
                            if (r_shipcnt + c_one == c_nships) begin
                                r_state <= S_ARMED;
                                r_alive <= c_nships;
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_errled <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    // A shot on an already-sunk cell finds w_qhit low and counts nothing.
                    if (hit && w_qhit) begin
                        r_map <= r_map & ~w_qsel;
                        if (r_alive != '0) begin
                            r_alive <= r_alive - c_one;
                            if (r_alive == c_one) begin
                                r_state    <= S_OVER;
                                r_gameover <= 1'b1;
                                r_ready    <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ship_placer.sv
// ============================================================================
// Module      : tb_ship_placer
// Description : Directed scoreboard bench for ship_placer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ship_placer;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       nrst = 1'b0;
    logic [1:0] rowsel = '0;
    logic [1:0] colsel = '0;
    logic       btnplace = 1'b0;
    logic       btnclr = 1'b0;
    logic [1:0] qrow = '0;
    logic [1:0] qcol = '0;
    logic       hit = 1'b0;
    logic       qship, ready, gameover, errled;
    logic [2:0] shipcnt, alive;

    ship_placer #(
        .ROWS(4), .COLS(4), .NSHIPS(4), .RW(2), .CW(2), .NW(3)
    ) dut (
        .clk(clk), .nrst(nrst), .rowsel(rowsel), .colsel(colsel),
        .btnplace(btnplace), .btnclr(btnclr), .qrow(qrow), .qcol(qcol),
        .hit(hit), .qship(qship), .ready(ready), .gameover(gameover),
        .shipcnt(shipcnt), .alive(alive), .errled(errled)
    );

    initial forever #5 clk = clk_en ? ~clk : clk;

    // Expected state of the board, tracked by hand alongside the stimulus.
    logic       e_ready = 0, e_go = 0, e_err = 0;
    logic [2:0] e_cnt = 0, e_alive = 0;

    string      sb_name[$];
    logic [9:0] sb_exp[$];
    event       sample;
    int         checks = 0;
    int         errors = 0;

    // Monitor: whenever an observation is presented, pop and compare.
    initial forever begin
        logic [9:0] obs, exp;
        string      nm;
        @(sample);
        while (sb_exp.size() > 0) begin
            exp = sb_exp.pop_front();
            nm  = sb_name.pop_front();
            obs = {qship, ready, gameover, errled, shipcnt, alive};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s got q/rdy/go/err/cnt/alive=%b_%b_%b_%b_%0d_%0d required %b_%b_%b_%b_%0d_%0d",
                         nm, obs[9], obs[8], obs[7], obs[6], obs[5:3], obs[2:0],
                         exp[9], exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
            end
        end
    end

    task automatic chk(input string nm, input int r, input int c, input logic eq);
        qrow = 2'(r);
        qcol = 2'(c);
        #1;
        sb_name.push_back(nm);
        sb_exp.push_back({eq, e_ready, e_go, e_err, e_cnt, e_alive});
        -> sample;
        #1;
    endtask

    task automatic press(input int r, input int c);
        @(negedge clk);
        rowsel = 2'(r);
        colsel = 2'(c);
        btnplace = 1'b1;
        repeat (4) @(negedge clk);
        btnplace = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_press();
        @(negedge clk);
        btnclr = 1'b1;
        repeat (4) @(negedge clk);
        btnclr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic shoot(input int r, input int c);
        @(negedge clk);
        qrow = 2'(r);
        qcol = 2'(c);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic sweep_empty(input string nm);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk(nm, r, c, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        chk("reset", 0, 0, 1'b0);

        // Partial placement, then asynchronous reset with the clock stopped.
        press(0, 0); e_cnt = 1;
        press(1, 2); e_cnt = 2;
        chk("pre_arst_cell", 1, 2, 1'b1);
        @(negedge clk);
        clk_en = 1'b0;
        #20;
        nrst = 1'b0;
        e_cnt = 0;
        chk("arst_async", 1, 2, 1'b0);
        #10;
        nrst = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        sweep_empty("arst_map");

        // Main placement with a duplicate and a held button.
        press(0, 0); e_cnt = 1;
        chk("place_00", 0, 0, 1'b1);
        shoot(0, 0);
        chk("hit_in_place", 0, 0, 1'b1);
        press(1, 2); e_cnt = 2;
        chk("place_12", 1, 2, 1'b1);
        press(1, 2); e_err = 1;
        chk("dup_12", 1, 2, 1'b1);
        press(3, 3); e_err = 0; e_cnt = 3;
        chk("place_33", 3, 3, 1'b1);

        @(negedge clk);
        rowsel = 2'd2;
        colsel = 2'd1;
        btnplace = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold_2edges", 2, 1, 1'b0);
        @(negedge clk);
        e_cnt = 4; e_alive = 4; e_ready = 1;
        chk("hold_3edges", 2, 1, 1'b1);
        repeat (17) @(negedge clk);
        chk("hold_20", 2, 1, 1'b1);
        btnplace = 1'b0;
        repeat (3) @(negedge clk);
        chk("armed_00", 0, 0, 1'b1);
        chk("armed_12", 1, 2, 1'b1);
        chk("armed_33", 3, 3, 1'b1);
        chk("armed_01", 0, 1, 1'b0);

        press(0, 1);
        chk("armed_place_ign", 0, 1, 1'b0);

        // Hits in the armed state.
        shoot(1, 2); e_alive = 3;
        chk("hit_12", 1, 2, 1'b0);
        shoot(1, 2);
        chk("rehit_12", 1, 2, 1'b0);
        shoot(0, 0); e_alive = 2;
        chk("hit_00", 0, 0, 1'b0);
        shoot(3, 3); e_alive = 1;
        chk("hit_33", 3, 3, 1'b0);
        shoot(2, 1); e_alive = 0; e_go = 1; e_ready = 0;
        chk("hit_21_over", 2, 1, 1'b0);

        press(2, 2);
        chk("over_place_ign", 2, 2, 1'b0);

        clear_press();
        e_cnt = 0; e_go = 0;
        sweep_empty("clear_map");

        // Simultaneous place and clear: clear wins.
        @(negedge clk);
        rowsel = 2'd1;
        colsel = 2'd1;
        btnplace = 1'b1;
        btnclr = 1'b1;
        repeat (4) @(negedge clk);
        btnplace = 1'b0;
        btnclr = 1'b0;
        repeat (3) @(negedge clk);
        chk("place_clr_same", 1, 1, 1'b0);

        press(1, 1); e_cnt = 1;
        chk("after_clear_place", 1, 1, 1'b1);

        #5;
        if (sb_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
